// File: rtl/rule110_seed_loader.sv
// Seed assembler: WORD-bit beats -> WIDTH-bit load for the Rule 110 stage.
// Define RULE110_SEED_LAST_CHECK_EN to enable s_last framing checks and frame_err.
module rule110_seed_loader #(
  parameter int WIDTH = 512,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WORD-1:0]  s_data,
  input  logic             s_last,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             seeded,
  output logic [31:0]      gen_count,
  output logic             frame_err
);

  localparam int BEATS = WIDTH / WORD;
  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  typedef enum logic {
    FILL,
    LOAD
  } state_t;

  state_t        state;
  logic [IW-1:0] beat_idx;
  logic          take;
  logic          at_end;

  assign take   = s_valid & s_ready;
  assign at_end = (beat_idx == LAST_IDX);

`ifndef RULE110_SEED_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = s_last;
  assign frame_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= FILL;
      beat_idx  <= '0;
      s_ready   <= 1'b1;
      load      <= 1'b0;
      data      <= '0;
      seeded    <= 1'b0;
      gen_count <= '0;
`ifdef RULE110_SEED_LAST_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
`ifdef RULE110_SEED_LAST_CHECK_EN
      frame_err <= 1'b0;
`endif
      // Count restarts on the edge the automaton captures the seed.
      if (load) begin
        gen_count <= '0;
        seeded    <= 1'b1;
      end else if (seeded && gen_count != 32'hFFFF_FFFF) begin
        gen_count <= gen_count + 32'd1;
      end

      unique case (state)
        LOAD: begin
          state    <= FILL;
          load     <= 1'b0;
          s_ready  <= 1'b1;
          beat_idx <= '0;
        end
        FILL: begin
          if (take) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_idx == IW'(k)) begin
                data[k*WORD +: WORD] <= s_data;
              end
            end
`ifdef RULE110_SEED_LAST_CHECK_EN
            if (at_end && s_last) begin
              state    <= LOAD;
              load     <= 1'b1;
              s_ready  <= 1'b0;
              beat_idx <= '0;
            end else if (at_end || s_last) begin
              beat_idx  <= '0;
              frame_err <= 1'b1;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
`else
            if (at_end) begin
              state    <= LOAD;
              load     <= 1'b1;
              s_ready  <= 1'b0;
              beat_idx <= '0;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rule110_seed_loader.sv
// Directed self-checking bench for rule110_seed_loader.
// Macro-dependent scenarios follow RULE110_SEED_LAST_CHECK_EN.
module tb_rule110_seed_loader;

  localparam int WIDTH = 512;
  localparam int WORD  = 32;
  localparam int BEATS = 16;

  logic             clk = 1'b0;
  logic             areset;
  logic             s_valid;
  logic             s_ready;
  logic [WORD-1:0]  s_data;
  logic             s_last;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             seeded;
  logic [31:0]      gen_count;
  logic             frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  rule110_seed_loader #(
    .WIDTH(WIDTH),
    .WORD (WORD)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .load     (load),
    .data     (data),
    .seeded   (seeded),
    .gen_count(gen_count),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_frame(input logic [31:0] base,
                            input int last_pos,
                            input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(k);
      s_last  = (k == last_pos);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic test_reset;
    areset  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    #2;
    n_checks++;
    if ({s_ready, load, seeded, frame_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1000",
               {s_ready, load, seeded, frame_err});
    end
    n_checks++;
    if (gen_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_gen: got %0d want 0", gen_count);
    end
    n_checks++;
    if (data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", data);
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_frame;
    logic [WIDTH-1:0] exp_d;
    int early_load;
    exp_d      = '0;
    exp_d[0]   = 1'b1;
    early_load = 0;
    for (int k = 0; k < BEATS; k++) begin
      s_valid = 1'b1;
      s_data  = (k == 0) ? 32'h0000_0001 : 32'h0;
      s_last  = (k == BEATS - 1);
      @(posedge clk); #1;
      if (k < BEATS - 1 && load) early_load++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (early_load !== 0) begin
      n_fail++;
      $display("FAIL clean_early_load: got %0d want 0", early_load);
    end
    n_checks++;
    if ({load, s_ready, frame_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL clean_load_cycle: got %b want 100",
               {load, s_ready, frame_err});
    end
    n_checks++;
    if (data !== exp_d) begin
      n_fail++;
      $display("FAIL clean_data: got %h want %h", data, exp_d);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({load, s_ready, seeded} !== 3'b011) begin
      n_fail++;
      $display("FAIL clean_after: got %b want 011",
               {load, s_ready, seeded});
    end
    for (int n = 0; n < 4; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      n_checks++;
      if (gen_count !== 32'(n)) begin
        n_fail++;
        $display("FAIL clean_gen%0d: got %0d want %0d", n, gen_count, n);
      end
    end
  endtask

  task automatic test_async_reset;
    n_checks++;
    if (seeded !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_seeded: got %b want 1", seeded);
    end
    #3;
    areset = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, load, seeded, frame_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL async_flags: got %b want 1000",
               {s_ready, load, seeded, frame_err});
    end
    n_checks++;
    if (gen_count !== 32'd0 || data !== '0) begin
      n_fail++;
      $display("FAIL async_gen_data: got gen=%0d data=%h want 0",
               gen_count, data);
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_gappy;
    int nload;
    int at;
    logic [WIDTH-1:0] snap;
    nload = 0;
    at    = -1;
    snap  = '0;
    for (int c = 0; c < 32; c++) begin
      s_valid = (c % 2 == 0);
      s_data  = s_valid ? 32'h1000_0000 + 32'(c / 2) : 32'hDEAD_BEEF;
      s_last  = s_valid && (c / 2 == BEATS - 1);
      @(posedge clk); #1;
      if (load) begin
        nload++;
        at   = c;
        snap = data;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (nload !== 1 || at !== 30) begin
      n_fail++;
      $display("FAIL gappy_load: got %0d loads at %0d want 1 at 30",
               nload, at);
    end
    for (int k = 0; k < BEATS; k++) begin
      n_checks++;
      if (snap[k*WORD +: WORD] !== 32'h1000_0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL gappy_slot%0d: got %h want %h", k,
                 snap[k*WORD +: WORD], 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  function automatic logic [31:0] b2b_word(input int i);
    return (i < BEATS) ? 32'hA000_0000 + 32'(i)
                       : 32'hB000_0000 + 32'(i - BEATS);
  endfunction

  task automatic test_back_to_back;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    int widx;
    int nl;
    int cyc;
    int first;
    int second;
    logic acc;
    for (int k = 0; k < BEATS; k++) begin
      exp_a[k*WORD +: WORD] = b2b_word(k);
      exp_b[k*WORD +: WORD] = b2b_word(k + BEATS);
    end
    widx    = 0;
    nl      = 0;
    cyc     = 0;
    first   = -1;
    second  = -1;
    s_valid = 1'b1;
    s_data  = b2b_word(0);
    s_last  = 1'b0;
    while (nl < 2 && cyc < 40) begin
      acc = s_ready & s_valid;
      @(posedge clk); #1;
      if (acc) widx++;
      if (load) begin
        nl++;
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_in_load: got %b want 0", s_ready);
        end
        n_checks++;
        if (nl == 1) begin
          first = cyc;
          if (data !== exp_a) begin
            n_fail++;
            $display("FAIL b2b_data_a: got %h want %h", data, exp_a);
          end
        end else begin
          second = cyc;
          if (data !== exp_b) begin
            n_fail++;
            $display("FAIL b2b_data_b: got %h want %h", data, exp_b);
          end
        end
      end
      cyc++;
      s_valid = (widx < 2 * BEATS);
      s_data  = b2b_word(widx);
      s_last  = (widx % BEATS == BEATS - 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (nl !== 2 || first !== 15 || second !== 32) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d loads at %0d,%0d want 2 at 15,32",
               nl, first, second);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    logic [WIDTH-1:0] exp_d;
    for (int k = 0; k < BEATS; k++)
      exp_d[k*WORD +: WORD] = 32'hD000_0000 + 32'(k);
    send_frame(32'hC000_0000, -1, 8);
    #3;
    areset = 1'b1;
    #1;
    n_checks++;
    if ({s_ready, load, seeded, frame_err} !== 4'b1000 ||
        gen_count !== 32'd0 || data !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got flags=%b gen=%0d want 1000 gen=0 data=0",
               {s_ready, load, seeded, frame_err}, gen_count);
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
    send_frame(32'hD000_0000, BEATS - 1, BEATS - 1);
    n_checks++;
    if (load !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_early_load: got %b want 0", load);
    end
    s_valid = 1'b1;
    s_data  = 32'hD000_000F;
    s_last  = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (load !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_load: got %b want 1", load);
    end
    n_checks++;
    if (data !== exp_d) begin
      n_fail++;
      $display("FAIL midreset_data: got %h want %h", data, exp_d);
    end
    @(posedge clk); #1;
  endtask

`ifdef RULE110_SEED_LAST_CHECK_EN
  task automatic test_early_last;
    logic [WIDTH-1:0] exp_d;
    for (int k = 0; k < BEATS; k++)
      exp_d[k*WORD +: WORD] = 32'h2000_0000 + 32'(k);
    send_frame(32'h3000_0000, 5, 6);
    n_checks++;
    if ({frame_err, load} !== 2'b10) begin
      n_fail++;
      $display("FAIL early_err: got %b want 10", {frame_err, load});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({frame_err, load} !== 2'b00) begin
      n_fail++;
      $display("FAIL early_pulse_end: got %b want 00", {frame_err, load});
    end
    send_frame(32'h2000_0000, BEATS - 1, BEATS);
    n_checks++;
    if ({load, frame_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL early_reload: got %b want 10", {load, frame_err});
    end
    n_checks++;
    if (data !== exp_d) begin
      n_fail++;
      $display("FAIL early_reload_data: got %h want %h", data, exp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_missing_last;
    send_frame(32'h4000_0000, BEATS - 1, BEATS);
    n_checks++;
    if (load !== 1'b1) begin
      n_fail++;
      $display("FAIL missing_preload: got %b want 1", load);
    end
    @(posedge clk); #1;
    n_checks++;
    if (gen_count !== 32'd0) begin
      n_fail++;
      $display("FAIL missing_gen0: got %0d want 0", gen_count);
    end
    send_frame(32'h5000_0000, -1, BEATS);
    n_checks++;
    if ({load, frame_err} !== 2'b01 || gen_count !== 32'd16) begin
      n_fail++;
      $display("FAIL missing_err: got flags=%b gen=%0d want 01 gen=16",
               {load, frame_err}, gen_count);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({load, frame_err} !== 2'b00 || gen_count !== 32'd17) begin
      n_fail++;
      $display("FAIL missing_after: got flags=%b gen=%0d want 00 gen=17",
               {load, frame_err}, gen_count);
    end
  endtask
`else
  task automatic test_last_ignored;
    logic [WIDTH-1:0] exp_d;
    int nerr;
    int nl;
    for (int k = 0; k < BEATS; k++)
      exp_d[k*WORD +: WORD] = 32'hE000_0000 + 32'(k);
    nerr = 0;
    nl   = 0;
    for (int k = 0; k < BEATS; k++) begin
      s_valid = 1'b1;
      s_data  = 32'hE000_0000 + 32'(k);
      s_last  = (k == 5);
      @(posedge clk); #1;
      if (frame_err) nerr++;
      if (k < BEATS - 1 && load) nl++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (nerr !== 0 || nl !== 0) begin
      n_fail++;
      $display("FAIL ignored_early: got err=%0d load=%0d want 0,0", nerr, nl);
    end
    n_checks++;
    if ({load, frame_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignored_load: got %b want 10", {load, frame_err});
    end
    n_checks++;
    if (data !== exp_d) begin
      n_fail++;
      $display("FAIL ignored_data: got %h want %h", data, exp_d);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({load, frame_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignored_after: got %b want 00", {load, frame_err});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_frame();
    test_async_reset();
    test_gappy();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef RULE110_SEED_LAST_CHECK_EN
    test_early_last();
    test_missing_last();
`else
    test_last_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rule110_seed_loader.md
# rule110_seed_loader

Upstream feeder for the 512-cell Rule 110 automaton stage. Accepts a seed pattern as a stream of WORD-bit beats with a valid/ready handshake and assembles it into a WIDTH-bit vector. On frame completion it issues a one-cycle `load` with `data` into the automaton. Also counts the generations the automaton has stepped since the last load.

## Interface
- `WIDTH`, 512, cell count; must equal the automaton width and be a multiple of `WORD`
- `WORD`, 32, beat width; BEATS = WIDTH/WORD (16 at defaults)
- `clk`  in  1  rising-edge clock
- `areset`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  beat valid
- `s_ready`  out  1  loader can accept a beat
- `s_data`  in  WORD  beat payload; beat k fills `data[k*WORD +: WORD]`, so beat 0 is the LSB word
- `s_last`  in  1  marks the final beat of a frame
- `load`  out  1  one-cycle load strobe to the automaton
- `data`  out  WIDTH  assembled seed; meaningful only while `load`=1
- `seeded`  out  1  set by the first load; cleared only by reset
- `gen_count`  out  32  automaton generations since the last load; saturating
- `frame_err`  out  1  one-cycle pulse on a framing violation

## Operation
- A beat transfers on a rising edge with `s_valid` & `s_ready`.
- Two states:
  - FILL: `s_ready`=1, `load`=0. Each accepted beat writes `s_data` into slot `beat_idx`, then `beat_idx` increments.
  - LOAD: `s_ready`=0, `load`=1, lasting exactly one cycle. Next state is always FILL with `beat_idx`=0.
- FILL→LOAD when the beat accepted has `beat_idx`=BEATS-1 and `s_last`=1.
- Framing checks (macro on):
  - Early `s_last`: a beat with `s_last`=1 and `beat_idx`<BEATS-1.
  - Missing `s_last`: beat BEATS-1 accepted with `s_last`=0.
  - On either violation: drop the frame, set `beat_idx` to 0, stay in FILL, and pulse `frame_err` on the following cycle.
  - No load occurs. Already-written slots of `data` are not restored.
- `gen_count`:
  - Cleared to 0 on the edge where `load`=1.
  - On every later edge with `load`=0 and `seeded`=1, it increments, saturating at 0xFFFF_FFFF.
  - Before the first load it holds 0.
- `gen_count` keeps counting during FILL, because the automaton keeps stepping while `load`=0.

## Timing
- Reset values: state FILL, `beat_idx`=0, `s_ready`=1, `load`=0, `data`=0, `seeded`=0, `gen_count`=0, `frame_err`=0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Final beat accepted at edge T:
  - `load`=1 during cycle T..T+1, with `data` complete.
  - The automaton captures at edge T+1, and `gen_count` becomes 0 at that same edge.
  - At edge T+1+n, `gen_count`=n, which equals the number of automaton steps applied.
- `s_ready` is low only during the LOAD cycle. Back-to-back frames complete every BEATS+1 cycles.
- `s_valid` gaps are allowed anywhere; state and `beat_idx` hold while no beat transfers.
- A beat presented during LOAD is not accepted; the source holds it.
- `areset` takes effect immediately, mid-frame or during LOAD. The partial frame is discarded, and `seeded` and `gen_count` clear.
- `frame_err` is never asserted in the same cycle as `load`.

## Configuration
- Macro `RULE110_SEED_LAST_CHECK_EN`:
  - Defined: `s_last` framing checks and `frame_err` are active as described above.
  - Undefined: `s_last` is ignored, and every BEATS-th accepted beat completes a frame and triggers LOAD. `frame_err` is tied to 0.

## Test plan
All scenarios use WIDTH=512, WORD=32.
- Reset: assert `areset` asynchronously mid-cycle -> immediately `s_ready`=1, `load`=0, `data`=0, `seeded`=0, `gen_count`=0, `frame_err`=0.
- Clean frame: 16 back-to-back beats, beat 0 = 0x0000_0001, rest 0, `s_last` on beat 15 -> `load`=1 for exactly one cycle with `data`=512'h1; `s_ready`=0 that cycle; `seeded`=1; `gen_count` reads 0,1,2,3 on the following edges.
- Early last (macro on): `s_last` on beat 5 -> `frame_err` one-cycle pulse, no `load`; the next clean 16-beat frame loads correctly with all 16 words in the right slots.
- Missing last (macro on): 16 beats with `s_last`=0 -> no `load`, `frame_err` pulse; `gen_count` unaffected.
- Gappy source: `s_valid` toggling 1/0 over 32 cycles, word k = 0x1000_0000+k -> single `load` after the 16th accepted beat; `data[k*32 +: 32]`=0x1000_0000+k. A beat held during LOAD is taken on the next cycle as beat 0.
- Reset mid-frame, then macro off: `areset` after 8 beats -> a full 16 beats is still needed for `load`. With the macro undefined and `s_last` on beat 5, `load` still fires after beat 15 and `frame_err` stays 0.
